dmx3_64bit_reg: RTL and testbench

DMX3_64BIT_REG -- requirements
Module: dmx3_64bit_reg

---
 rtl/dmx3_64bit_reg.sv | 113 +++++++++++
 tb/tb_dmx3_64bit_reg.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmx3_64bit_reg.sv
// dmx3_64bit_reg: 1:3 demultiplexer with one-entry holding registers.
// One input stream is steered by in_sel to one of three ready/valid output
// ports. in_sel = 11 discards the word and bumps a saturating drop counter.
// Each output is a single register with full back-to-back throughput: a port
// can be drained and reloaded on the same edge.

module dmx3_64bit_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic             drop_pulse,
    output logic [7:0]       drop_cnt
);

    localparam logic [1:0] SEL_DROP = 2'b11;

    // Per-port holding state, indexed by port number.
    logic [2:0]       valid_q;
    logic [WIDTH-1:0] data_q [3];
    logic [2:0]       out_ready;
    logic [2:0]       load;
    logic             drop_xfer;
    logic             drop_pulse_q;
    logic [7:0]       drop_cnt_q;

    assign out_ready = {out2_ready, out1_ready, out0_ready};

    // Input may enter a port if it is empty or is being drained this cycle;
    // discards are always accepted.
    always_comb begin
        // NOTE: a default on every path keeps always_comb free of inferred latches.
        in_ready = 1'b1;
        case (in_sel)
            2'b00:   in_ready = !valid_q[0] || out_ready[0];
            2'b01:   in_ready = !valid_q[1] || out_ready[1];
            2'b10:   in_ready = !valid_q[2] || out_ready[2];
            default: in_ready = 1'b1;
        endcase
    end

    // Decode the accepted input transfer into a one-hot port load or a drop.
    always_comb begin
        load      = 3'b000;
        drop_xfer = 1'b0;
        if (in_valid && in_ready) begin
            case (in_sel)
                2'b00:   load = 3'b001;
                2'b01:   load = 3'b010;
                2'b10:   load = 3'b100;
                default: drop_xfer = (in_sel == SEL_DROP);
            endcase
        end
    end

    // Holding registers: load wins over drain, so a simultaneous drain and
    // load stays full with the new word; unaddressed ports keep their state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 3'b000;
            // NOTE: the data registers are cleared on reset because their
            // contents are visible on the output ports, not just internal storage.
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                // NOTE: sequential state uses non-blocking assignments so every
                // register samples pre-edge values, independent of statement order.
                valid_q[k] <= load[k] || (valid_q[k] && !out_ready[k]);
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    // Discard bookkeeping: one-cycle pulse per dropped word, saturating count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            drop_pulse_q <= drop_xfer;
            if (drop_xfer && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign out0_data  = data_q[0];
    assign out1_data  = data_q[1];
    assign out2_data  = data_q[2];
    assign out0_valid = valid_q[0];
    assign out1_valid = valid_q[1];
    assign out2_valid = valid_q[2];
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_dmx3_64bit_reg.sv
// Directed testbench for dmx3_64bit_reg: reset behaviour, routing, stall,
// streaming, isolation between ports, drop counter saturation and
// asynchronous reset of full ports.

module tb_dmx3_64bit_reg;

    localparam int WIDTH = 64;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data, out1_data, out2_data;
    logic             out0_valid, out1_valid, out2_valid;
    logic             out0_ready, out1_ready, out2_ready;
    logic             drop_pulse;
    logic [7:0]       drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    dmx3_64bit_reg #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [63:0] held;
        logic [7:0]  exp_cnt;

        reset_n    = 1'b0;
        in_data    = '0;
        in_sel     = 2'b00;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;

        // Reset state
        #12;
        check("rst_v0", {63'd0, out0_valid}, 64'd0);
        check("rst_v1", {63'd0, out1_valid}, 64'd0);
        check("rst_v2", {63'd0, out2_valid}, 64'd0);
        check("rst_d0", out0_data, 64'd0);
        check("rst_d1", out1_data, 64'd0);
        check("rst_d2", out2_data, 64'd0);
        check("rst_dp", {63'd0, drop_pulse}, 64'd0);
        check("rst_dc", {56'd0, drop_cnt}, 64'd0);

        @(negedge clk);
        reset_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check($sformatf("post_rst_ready_sel%0d", s), {63'd0, in_ready}, 64'd1);
        end
        step();

        // Route one word to port 1
        in_valid = 1'b1;
        in_sel   = 2'b01;
        in_data  = 64'h0123_4567_89AB_CDEF;
        step();
        in_valid = 1'b0;
        #1;
        check("p1_valid", {63'd0, out1_valid}, 64'd1);
        check("p1_data", out1_data, 64'h0123_4567_89AB_CDEF);
        check("p1_v0_idle", {63'd0, out0_valid}, 64'd0);
        check("p1_v2_idle", {63'd0, out2_valid}, 64'd0);

        // Port 1 stalled: new word for port 1 must wait
        in_valid = 1'b1;
        in_sel   = 2'b01;
        in_data  = 64'hFEED_FACE_CAFE_BEEF;
        #1;
        check("stall_ready", {63'd0, in_ready}, 64'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("stall_data_c%0d", c), out1_data, 64'h0123_4567_89AB_CDEF);
            check($sformatf("stall_rdy_c%0d", c), {63'd0, in_ready}, 64'd0);
        end
        out1_ready = 1'b1;
        #1;
        check("unstall_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("b2b_valid", {63'd0, out1_valid}, 64'd1);
        check("b2b_data", out1_data, 64'hFEED_FACE_CAFE_BEEF);
        // Drain with no load: empty, data retained
        step();
        check("drain_valid", {63'd0, out1_valid}, 64'd0);
        check("drain_keep", out1_data, 64'hFEED_FACE_CAFE_BEEF);
        out1_ready = 1'b0;

        // Stream of 10 words to port 2
        out2_ready = 1'b1;
        in_sel     = 2'b10;
        in_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 64'hA000_0000_0000_1000 + 64'(i);
            #1;
            check($sformatf("stream_rdy_%0d", i), {63'd0, in_ready}, 64'd1);
            step();
            check($sformatf("stream_v_%0d", i), {63'd0, out2_valid}, 64'd1);
            check($sformatf("stream_d_%0d", i), out2_data, 64'hA000_0000_0000_1000 + 64'(i));
        end
        in_valid = 1'b0;
        step();
        check("stream_end_v", {63'd0, out2_valid}, 64'd0);
        out2_ready = 1'b0;

        // Port 0 full and stalled, port 2 still accepts
        in_valid = 1'b1;
        in_sel   = 2'b00;
        in_data  = 64'h0000_0000_B0B0_B0B0;
        step();
        in_sel  = 2'b10;
        in_data = 64'h0000_0000_C2C2_C2C2;
        #1;
        check("iso_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("iso_v2", {63'd0, out2_valid}, 64'd1);
        check("iso_d2", out2_data, 64'h0000_0000_C2C2_C2C2);
        check("iso_v0", {63'd0, out0_valid}, 64'd1);
        check("iso_d0", out0_data, 64'h0000_0000_B0B0_B0B0);
        check("iso_v1", {63'd0, out1_valid}, 64'd0);
        in_sel = 2'b00;
        #1;
        check("iso_ready_sel0", {63'd0, in_ready}, 64'd0);
        in_sel = 2'b11;
        #1;
        check("iso_ready_sel3", {63'd0, in_ready}, 64'd1);

        // Drain everything
        out0_ready = 1'b1;
        out2_ready = 1'b1;
        step();
        check("drained_v0", {63'd0, out0_valid}, 64'd0);
        check("drained_v2", {63'd0, out2_valid}, 64'd0);
        out0_ready = 1'b0;
        out2_ready = 1'b0;

        // 260 discards: pulse every cycle, counter saturates at 255
        in_sel   = 2'b11;
        in_data  = 64'hDEAD_DEAD_DEAD_DEAD;
        in_valid = 1'b1;
        exp_cnt  = 8'd0;
        for (int i = 0; i < 260; i++) begin
            step();
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            check($sformatf("drop_pulse_%0d", i), {63'd0, drop_pulse}, 64'd1);
            check($sformatf("drop_cnt_%0d", i), {56'd0, drop_cnt}, {56'd0, exp_cnt});
        end
        in_valid = 1'b0;
        step();
        check("drop_pulse_off", {63'd0, drop_pulse}, 64'd0);
        check("drop_cnt_hold", {56'd0, drop_cnt}, 64'd255);
        check("drop_v0", {63'd0, out0_valid}, 64'd0);
        check("drop_v1", {63'd0, out1_valid}, 64'd0);
        check("drop_v2", {63'd0, out2_valid}, 64'd0);
        check("drop_d0_keep", out0_data, 64'h0000_0000_B0B0_B0B0);

        // Fill all three ports, then reset asynchronously mid-cycle
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_sel  = 2'(k);
            in_data = 64'h5555_0000_0000_0000 + 64'(k);
            step();
        end
        in_valid = 1'b0;
        #1;
        check("full_v0", {63'd0, out0_valid}, 64'd1);
        check("full_v1", {63'd0, out1_valid}, 64'd1);
        check("full_v2", {63'd0, out2_valid}, 64'd1);
        held = out1_data;
        check("full_d1", held, 64'h5555_0000_0000_0001);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_v0", {63'd0, out0_valid}, 64'd0);
        check("arst_v1", {63'd0, out1_valid}, 64'd0);
        check("arst_v2", {63'd0, out2_valid}, 64'd0);
        check("arst_dc", {56'd0, drop_cnt}, 64'd0);
        check("arst_d2", out2_data, 64'd0);
        // No transfer while reset is held
        in_valid = 1'b1;
        in_sel   = 2'b00;
        in_data  = 64'h1111_2222_3333_4444;
        step();
        check("arst_noload_v0", {63'd0, out0_valid}, 64'd0);
        check("arst_noload_d0", out0_data, 64'd0);
        in_valid = 1'b0;

        // First edge after release accepts input
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 2'b00;
        #1;
        check("rel_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("rel_v0", {63'd0, out0_valid}, 64'd1);
        check("rel_d0", out0_data, 64'h1111_2222_3333_4444);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
